if_prefetch: RTL and testbench

//  Fetch front end feeding the IF/ID path of the RV core. Reads a byte-wide instruction ROM
//  and assembles little-endian 32-bit words, buffering them with their PCs in a small FIFO.

---
 rtl/if_prefetch_pkg.sv | 34 +++
 rtl/if_prefetch_if.sv | 31 +++
 rtl/if_prefetch_sync_fifo.sv | 93 +++++++++
 rtl/if_prefetch.sv | 175 +++++++++++++++++
 tb/tb_if_prefetch.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// if_prefetch_pkg
// Shared types and constants for the instruction prefetch front end.
//   XLEN / ILEN       : datapath and instruction widths
//   EXIT_INSN         : all-zero word that stops fetching once enqueued
//   DEFAULT_RESET_PC  : default first fetch address
//   fetch_entry_t     : one FIFO entry, instruction word plus its PC
//   fetch_state_t     : fetch FSM states
//   align_word()      : forces a byte address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package if_prefetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] EXIT_INSN        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

    // Low two address bits are meaningless for word fetch; clear them.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_if
// Valid/ready instruction handoff from the prefetcher to the decoder.
//   ins_valid : head word available
//   ins_ready : consumer accepts the head this cycle
//   ins_data  : head instruction word
//   ins_pc    : PC of the head word
// master = prefetcher side, slave = consumer side.
// -----------------------------------------------------------------------------
interface if_prefetch_if;

    logic                              ins_valid;
    logic                              ins_ready;
    logic [if_prefetch_pkg::ILEN-1:0]  ins_data;
    logic [if_prefetch_pkg::XLEN-1:0]  ins_pc;

    modport master (
        output ins_valid,
        output ins_data,
        output ins_pc,
        input  ins_ready
    );

    modport slave (
        input  ins_valid,
        input  ins_data,
        input  ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/if_prefetch_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a first-word-fall-through read port (rdata_o shows the
// head entry combinationally) and a synchronous flush.
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : drop all entries; overrides push and pop in the same cycle
//   push_i    : write wdata_i at the tail
//   wdata_i   : entry to write
//   pop_i     : advance the head (ignored when empty)
//   rdata_o   : head entry
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
//   count_o   : number of entries, log2(DEPTH)+1 bits so DEPTH is representable
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter type T     = logic [63:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         wdata_i,
    input  logic                     pop_i,
    output T                         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction fetch front end. Reads a byte-wide ROM four beats per word,
// assembles little-endian 32-bit words, queues {pc, word} in a small FIFO and
// hands them downstream over valid/ready. A redirect flushes everything and
// restarts at the new word-aligned PC; enqueuing the all-zero exit word halts
// fetching until the next redirect or reset.
//   clk, rst        : clock, synchronous active-high reset
//   mem_req         : byte read request this cycle
//   mem_addr        : byte address of the request
//   mem_rdata       : read data, one cycle after mem_req
//   mem_rvalid      : mem_rdata valid
//   redirect_valid  : flush and restart at redirect_pc
//   redirect_pc     : restart PC, low two bits ignored
//   ins             : instruction handoff (if_prefetch_if.master)
//   halted          : exit word enqueued, no further requests
// -----------------------------------------------------------------------------
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    if_prefetch_if.master     ins,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Fetch FSM and request side
    fetch_state_t    state_q;
    logic [1:0]      req_beat_q;      // next byte lane to request
    logic [XLEN-1:0] req_pc_q;        // word address being requested
    logic            halted_q;

    // Return side: which lane the byte arriving this cycle belongs to
    logic            ret_pend_q;      // a request was issued last cycle
    logic [1:0]      ret_beat_q;      // its byte lane
    logic [XLEN-1:0] asm_pc_q;        // PC of the word being assembled
    logic [7:0]      asm_byte_q [3];  // lanes 0..2; lane 3 goes straight to the FIFO

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    logic             tail_pending;
    logic             slot_free;
    logic             rx_ok;
    logic             push;
    logic             pop;
    logic [ILEN-1:0]  push_word;
    logic [2:0]       lane_we;

    // The word whose last byte returns this cycle is pushed at the coming edge
    // but is not yet in fifo_count. Counting it as a reserved slot keeps the
    // next word from starting when that push would fill the FIFO, so a push
    // can never meet a full FIFO.
    assign tail_pending = ret_pend_q && (ret_beat_q == 2'd3);
    assign slot_free    = !fifo_full &&
                          (({1'b0, fifo_count} + {{CNT_W{1'b0}}, tail_pending})
                           < (CNT_W + 1)'(DEPTH));

    // Beat 0 waits for space; beats 1..3 follow back-to-back once a word starts.
    assign mem_req  = !rst && !redirect_valid && (state_q == ST_FETCH) &&
                      ((req_beat_q != 2'd0) || slot_free);
    assign mem_addr = ADDR_W'(req_pc_q + {30'd0, req_beat_q});

    // Bytes returning in HALT belong to a request issued alongside the exit
    // word's push and are dropped, as is anything arriving during a redirect.
    assign rx_ok     = mem_rvalid && ret_pend_q && (state_q == ST_FETCH) && !redirect_valid;
    assign push      = rx_ok && (ret_beat_q == 2'd3);
    assign push_word = {mem_rdata, asm_byte_q[2], asm_byte_q[1], asm_byte_q[0]};

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = asm_pc_q;
        push_entry.insn = push_word;
    end

    assign pop = !fifo_empty && ins.ins_ready && !redirect_valid;

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ins.ins_valid = !fifo_empty;
    assign ins.ins_data  = head_entry.insn;
    assign ins.ins_pc    = head_entry.pc;
    assign halted        = halted_q;

    // Byte assembler: one write enable per lower lane.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane_we
            assign lane_we[gi] = rx_ok && (ret_beat_q == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                asm_byte_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (lane_we[k]) begin
                    asm_byte_q[k] <= mem_rdata;
                end
            end
        end
    end

    // Fetch FSM, request sequencing and return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            req_beat_q <= 2'd0;
            req_pc_q   <= RESET_PC;
            asm_pc_q   <= RESET_PC;
            ret_pend_q <= 1'b0;
            ret_beat_q <= 2'd0;
            halted_q   <= 1'b0;
        end else if (redirect_valid) begin
            // Any partially assembled word is abandoned: beat restarts at 0
            // and no request was issued this cycle, so nothing returns next.
            state_q    <= ST_FETCH;
            req_beat_q <= 2'd0;
            req_pc_q   <= align_word(redirect_pc);
            ret_pend_q <= 1'b0;
            ret_beat_q <= 2'd0;
            halted_q   <= 1'b0;
        end else begin
            ret_pend_q <= mem_req;
            ret_beat_q <= req_beat_q;
            if (mem_req) begin
                if (req_beat_q == 2'd0) begin
                    asm_pc_q <= req_pc_q;
                end
                if (req_beat_q == 2'd3) begin
                    req_pc_q <= req_pc_q + XLEN'(4);
                end
                req_beat_q <= req_beat_q + 2'd1;
            end
            if (push && (push_word == EXIT_INSN)) begin
                state_q    <= ST_HALT;
                halted_q   <= 1'b1;
                req_beat_q <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        halted;

    logic [7:0]  rom [256];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          req_cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;
    exp_t sb[$];

    if_prefetch_if ins_if();

    if_prefetch #(
        .DEPTH    (DEPTH),
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins            (ins_if),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Byte ROM: data returns exactly one cycle after the request.
    always @(posedge clk) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= 8'h00;
        end else begin
            mem_rvalid <= mem_req;
            mem_rdata  <= rom[mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_req === 1'b1) req_cnt <= req_cnt + 1;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {rom[b + 8'd3], rom[b + 8'd2], rom[b + 8'd1], rom[b]};
    endfunction

    task automatic sb_push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.insn = rom_word(pc);
        sb.push_back(e);
    endtask

    task automatic load_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'(i + 32);
        rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'ha0; rom[3] = 8'h00;
        rom[4] = 8'h93; rom[5] = 8'h05; rom[6] = 8'hb0; rom[7] = 8'h00;
    endtask

    // Leaves the bench at posedge+1 of cycle 0 after rst falls.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ins_if.ins_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b, expected 0", mem_req);
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %08h, expected 00000000", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (ins_if.ins_valid !== 1'b0) $display("FAIL reset_ins_valid: got %b, expected 0", ins_if.ins_valid);
        else pass_cnt++;
        total_cnt++;
        if (halted !== 1'b0) $display("FAIL reset_halted: got %b, expected 0", halted);
        else pass_cnt++;
        $display("reset: mem_req=%b mem_addr=%08h ins_valid=%b halted=%b",
                 mem_req, mem_addr, ins_if.ins_valid, halted);
    endtask

    // Startup sequence after a reset; shared by the basic and mid-run reset scenarios.
    task automatic run_startup(input string tag, input logic from_reset_mid);
        int   got;
        int   exp_cyc[2];
        exp_t e;
        exp_cyc[0] = 5;
        exp_cyc[1] = 9;
        e.pc = 32'h0; e.insn = 32'h00a00513; sb.push_back(e);
        e.pc = 32'h4; e.insn = 32'h00b00593; sb.push_back(e);
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total_cnt++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h0)
                    $display("FAIL %s_first_req: got req=%b addr=%08h, expected req=1 addr=00000000",
                             tag, mem_req, mem_addr);
                else pass_cnt++;
                if (from_reset_mid) begin
                    total_cnt++;
                    if (ins_if.ins_valid !== 1'b0)
                        $display("FAIL %s_valid_cleared: got %b, expected 0", tag, ins_if.ins_valid);
                    else pass_cnt++;
                end
            end
            if (ins_if.ins_valid === 1'b1 && ins_if.ins_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL %s_extra_word: got pc=%08h, expected no word", tag, ins_if.ins_pc);
                end else begin
                    e = sb.pop_front();
                    if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                        $display("FAIL %s_word: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                                 tag, ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                    else pass_cnt++;
                end
                total_cnt++;
                if (c != exp_cyc[got])
                    $display("FAIL %s_latency: got cycle %0d, expected cycle %0d", tag, c, exp_cyc[got]);
                else pass_cnt++;
                $display("%s: cycle=%0d pc=%08h insn=%08h", tag, c, ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 2) $display("FAIL %s_count: got %0d words, expected 2", tag, got);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load_rom();
        ins_if.ins_ready = 1'b1;
        do_reset();
        run_startup("basic", 1'b0);
    endtask

    task automatic test_stall();
        int   base;
        int   got;
        exp_t e;
        load_rom();
        ins_if.ins_ready = 1'b0;
        do_reset();
        base = req_cnt;
        for (int i = 0; i < 6; i++) sb_push(32'(4 * i));
        repeat (40) @(posedge clk);
        #1;
        total_cnt++;
        if (req_cnt - base != 4 * DEPTH)
            $display("FAIL stall_req_count: got %0d, expected %0d", req_cnt - base, 4 * DEPTH);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL stall_req_idle: got %b, expected 0", mem_req);
        else pass_cnt++;
        total_cnt++;
        if (ins_if.ins_valid !== 1'b1 || ins_if.ins_pc !== sb[0].pc || ins_if.ins_data !== sb[0].insn)
            $display("FAIL stall_head: got v=%b pc=%08h insn=%08h, expected v=1 pc=%08h insn=%08h",
                     ins_if.ins_valid, ins_if.ins_pc, ins_if.ins_data, sb[0].pc, sb[0].insn);
        else pass_cnt++;
        @(posedge clk); #1;
        ins_if.ins_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            if (ins_if.ins_valid === 1'b1) begin
                total_cnt++;
                e = sb.pop_front();
                if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                    $display("FAIL stall_word: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                             ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                else pass_cnt++;
                $display("stall: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 6) $display("FAIL stall_count: got %0d words, expected 6", got);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        int   got;
        exp_t e;
        load_rom();
        ins_if.ins_ready = 1'b0;
        do_reset();
        // cycle 10 is beat 2 of the word at pc 8; pcs 0 and 4 sit in the FIFO
        repeat (10) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL redirect_req_cycle: got %b, expected 0", mem_req);
        else pass_cnt++;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ins_if.ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40)
            $display("FAIL redirect_restart: got v=%b req=%b addr=%08h, expected v=0 req=1 addr=00000040",
                     ins_if.ins_valid, mem_req, mem_addr);
        else pass_cnt++;
        sb_push(32'h40);
        sb_push(32'h44);
        @(posedge clk); #1;
        ins_if.ins_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 2; c++) begin
            @(negedge clk);
            if (ins_if.ins_valid === 1'b1) begin
                total_cnt++;
                e = sb.pop_front();
                if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                    $display("FAIL redirect_word: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                             ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                else pass_cnt++;
                $display("redirect: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 2) $display("FAIL redirect_count: got %0d words, expected 2", got);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        int   got;
        int   base;
        exp_t e;
        load_rom();
        for (int i = 8; i < 12; i++) rom[i] = 8'h00;
        ins_if.ins_ready = 1'b1;
        do_reset();
        sb_push(32'h0);
        sb_push(32'h4);
        sb_push(32'h8);
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (ins_if.ins_valid === 1'b1) begin
                total_cnt++;
                e = sb.pop_front();
                if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                    $display("FAIL halt_word: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                             ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                else pass_cnt++;
                $display("halt: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 3) $display("FAIL halt_count: got %0d words, expected 3", got);
        else pass_cnt++;
        base = req_cnt;
        @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || ins_if.ins_valid !== 1'b0)
            $display("FAIL halt_state: got halted=%b v=%b, expected halted=1 v=0", halted, ins_if.ins_valid);
        else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        total_cnt++;
        if (req_cnt - base != 0 || halted !== 1'b1)
            $display("FAIL halt_no_req: got %0d requests halted=%b, expected 0 requests halted=1",
                     req_cnt - base, halted);
        else pass_cnt++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0)
            $display("FAIL halt_resume: got halted=%b req=%b addr=%08h, expected halted=0 req=1 addr=00000000",
                     halted, mem_req, mem_addr);
        else pass_cnt++;
        sb_push(32'h0);
        got = 0;
        for (int c = 0; c < 20 && got < 1; c++) begin
            @(negedge clk);
            if (ins_if.ins_valid === 1'b1) begin
                total_cnt++;
                e = sb.pop_front();
                if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                    $display("FAIL halt_refetch: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                             ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                else pass_cnt++;
                $display("halt_refetch: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 1) $display("FAIL halt_refetch_count: got %0d words, expected 1", got);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        int   base;
        int   got;
        exp_t e;
        load_rom();
        ins_if.ins_ready = 1'b0;
        do_reset();
        base = req_cnt;
        for (int i = 0; i < 5; i++) sb_push(32'(4 * i));
        // cycle 16: FIFO holds 3, the 4th word is pushed while the head pops
        repeat (16) @(posedge clk);
        #1;
        ins_if.ins_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL same_gate: got req=%b, expected 0", mem_req);
        else pass_cnt++;
        total_cnt++;
        e = sb.pop_front();
        if (ins_if.ins_valid !== 1'b1 || ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
            $display("FAIL same_pop: got v=%b pc=%08h insn=%08h, expected v=1 pc=%08h insn=%08h",
                     ins_if.ins_valid, ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
        else pass_cnt++;
        $display("same_cycle: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
        @(posedge clk); #1;
        ins_if.ins_ready = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        // count stayed at DEPTH-1, so exactly one further word fits
        total_cnt++;
        if (req_cnt - base != 20)
            $display("FAIL same_req_count: got %0d, expected 20", req_cnt - base);
        else pass_cnt++;
        ins_if.ins_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            if (ins_if.ins_valid === 1'b1) begin
                total_cnt++;
                e = sb.pop_front();
                if (ins_if.ins_pc !== e.pc || ins_if.ins_data !== e.insn)
                    $display("FAIL same_word: got pc=%08h insn=%08h, expected pc=%08h insn=%08h",
                             ins_if.ins_pc, ins_if.ins_data, e.pc, e.insn);
                else pass_cnt++;
                $display("same_cycle: pc=%08h insn=%08h", ins_if.ins_pc, ins_if.ins_data);
                got++;
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (got != 4) $display("FAIL same_count: got %0d words, expected 4", got);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        load_rom();
        ins_if.ins_ready = 1'b0;
        do_reset();
        // cycle 14: three words queued, fourth word at beat 2
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b0 || ins_if.ins_valid !== 1'b1)
            $display("FAIL rstmid_pre: got req=%b v=%b, expected req=0 v=1", mem_req, ins_if.ins_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        ins_if.ins_ready = 1'b1;
        sb.delete();
        run_startup("rstmid", 1'b1);
    endtask

    initial begin
        ins_if.ins_ready = 1'b0;
        load_rom();
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_halt();
        test_same_cycle();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
